bcd_scan_driver: RTL and testbench
==================================

// Module: bcd_scan_driver
// PURPOSE
//  Time-multiplexes NUM_DIGITS packed BCD digits onto one shared 4-bit data bus
//  and produces an active-low one-hot digit-select bus.
//  Sits directly upstream of the BCD-to-seven-segment decoder: data feeds the
//  decoder's data input, sel_n drives the digit commons.
//  Adds a per-digit dwell prescaler, a frame-coherent input snapshot,
//  leading-zero blanking and an anti-ghosting dead time.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned; >=2
//  SCAN_DIV      50000  clk cycles each digit is held; >=2
//  DEAD_CYCLES   2      cycles at the start of each dwell with all digits off; < SCAN_DIV
//  BLANK_LEADING 1      1 = blank leading zeros, 0 = show every digit
// PORTS
//  clk        in   1             system clock, rising edge
//  rst        in   1             synchronous reset, active-high
//  digits_in  in   4*NUM_DIGITS  packed BCD; digit 0 = [3:0] = least significant
//  data       out  4             BCD code of the active digit; 4'hF when blanked
//  sel_n      out  NUM_DIGITS    active-low one-hot digit enable; all 1 = no digit on
//  frame_start out 1             1-cycle pulse on the cycle digit 0 becomes active
// BEHAVIOUR
//  Clock/reset: single clock clk; rst synchronous, active-high, overrides every
//    other input on that edge.
//  Reset values: presc=0, idx=0, snapshot=0, data=4'h0, sel_n=~1 (digit 0 on),
//    frame_start=0.
//  Prescaler: presc counts 0..SCAN_DIV-1 and wraps; tick = (presc==SCAN_DIV-1).
//  Index: idx advances on a tick, NUM_DIGITS-1 -> 0 wrap.
//    frame_start=1 on the edge where idx wraps to 0.
//  Snapshot: the snapshot register is loaded from digits_in on the wrap edge
//    only. digits_in changes mid-frame never appear until the next frame.
//  Outputs are registered and computed from the next-state idx/presc.
//    data and sel_n change on the same edge, never skewed.
//    Latency: new digit visible 1 cycle after the tick edge.
//  Dead time: sel_n = all 1 while presc < DEAD_CYCLES; otherwise sel_n = ~(1<<idx).
//    data already holds the new digit during dead time.
//  Leading-zero blanking (BLANK_LEADING=1): digit i is blanked when it and every
//    more-significant digit equal 4'h0.
//    Digit 0 is never blanked, so an all-zero value shows a single "0".
//    Blanked digit: data=4'hF; the decoder's default blanks it; sel_n still asserted.
//  Invalid BCD (>9): passed through unchanged (the decoder shows it as blank).
//    A nonzero invalid digit counts as significant for blanking.
//  Reset mid-dwell: next cycle is exactly the reset state.
//    The scan restarts at digit 0 with a full dwell; snapshot cleared to 0.
//  DEAD_CYCLES=0: no dead time; sel_n switches directly between digits.
// STRUCTURE
//  Shared package disp_pkg: BCD_BLANK=4'hF constant, digit-index width function
//    clog2(NUM_DIGITS), digit_t typedef (logic [3:0]).
//  One sub-module: scan_prescaler (counter + tick + dead-time flag).
//  Blanking logic and output registers stay in the top module.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1 unless noted)
//  1 Reset: hold rst 3 cycles -> data=0, sel_n=4'b1110, frame_start=0;
//    no tick for the first 4 cycles after release.
//  2 Scan order: digits_in=16'h1234, run 2 frames -> after the first frame_start,
//    sel_n visits 1110,1101,1011,0111, 4 cycles each.
//    Each visit has 1 dead cycle (1111) first.
//    data = 4,3,2,1 on the matching digits.
//  3 Snapshot: change digits_in 16'h1234 -> 16'h5678 mid-frame -> the current
//    frame still shows 4,3,2,1; the next frame shows 8,7,6,5.
//  4 Leading zeros: 16'h0070 -> digits 3 and 2 data=F, digit 1=7, digit 0=0.
//    16'h0000 -> only digit 0 shows 0.
//    BLANK_LEADING=0 -> all four show 0.
//  5 Invalid/edge values: 16'h00A0 -> digit 1 data=A (not blanked), digit 0=0.
//    DEAD_CYCLES=0 -> sel_n is never 4'b1111 after reset.
//  6 Reset mid-operation: assert rst during digit 2's dwell -> next cycle is the
//    reset state; snapshot cleared; first frame_start occurs 16 cycles after release.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed BCD display path.
package disp_pkg;

    typedef logic [3:0] digit_t;

    // Code the downstream seven-segment decoder renders as an unlit digit.
    localparam digit_t BCD_BLANK = 4'hF;

    function automatic int idx_width(input int num_digits);
        return (num_digits < 2) ? 1 : $clog2(num_digits);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Per-digit dwell counter: wraps every SCAN_DIV cycles and flags the dead-time
// window of the upcoming cycle.
module scan_prescaler #(
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic dead_next
);

    localparam int PW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;

    assign tick = (presc == PW'(SCAN_DIV - 1));

    always_comb begin
        presc_next = tick ? '0 : presc + PW'(1);
    end

    // NOTE: the reset branch lives inside the clocked process, so rst acts only on a clk edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else begin
            presc <= presc_next;
        end
    end

    // dead_next describes the cycle that follows the coming edge, so the
    // registered outputs in the top module line up with the counter.
    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign dead_next = 1'b0;
        end else begin : g_dead
            assign dead_next = (presc_next < PW'(DEAD_CYCLES));
        end
    endgenerate

endmodule

// File: rtl/bcd_scan_driver.sv
// Scans packed BCD digits onto a shared 4-bit bus with one-hot active-low
// digit selects, frame-coherent snapshot, leading-zero blanking and dead time.
module bcd_scan_driver
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int DEAD_CYCLES   = 2,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              data,
    output logic [NUM_DIGITS-1:0]   sel_n,
    output logic                    frame_start
);

    localparam int IW = idx_width(NUM_DIGITS);

    logic                    tick;
    logic                    dead_next;
    logic                    wrap;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_next;
    logic [4*NUM_DIGITS-1:0] snap;
    logic [4*NUM_DIGITS-1:0] snap_next;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lead_zero;
    digit_t                  data_next;
    logic [NUM_DIGITS-1:0]   sel_next;

    scan_prescaler #(
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .dead_next (dead_next)
    );

    assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

    always_comb begin
        idx_next  = idx;
        snap_next = snap;
        if (tick) begin
            idx_next = wrap ? '0 : idx + IW'(1);
        end
        // The snapshot is taken only as digit 0 comes up, so a frame never mixes values.
        if (wrap) begin
            snap_next = digits_in;
        end
    end

    // A digit is blanked while it and every more-significant digit are zero;
    // digit 0 always shows so an all-zero value displays a single "0".
    always_comb begin
        lead_zero = 1'b1;
        blank     = '0;
        // NOTE: blocking assignments here build the running "all zero so far" chain within one evaluation.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_zero = lead_zero && (snap_next[4*i +: 4] == 4'h0);
            blank[i]  = lead_zero && (BLANK_LEADING != 0);
        end
    end

    always_comb begin
        data_next = BCD_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_next == IW'(i)) begin
                data_next = blank[i] ? BCD_BLANK : snap_next[4*i +: 4];
            end
        end
        sel_next = dead_next ? '1 : ~(NUM_DIGITS'(1) << idx_next);
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            snap        <= '0;
            data        <= 4'h0;
            sel_n       <= ~NUM_DIGITS'(1);
            frame_start <= 1'b0;
        end else begin
            idx         <= idx_next;
            snap        <= snap_next;
            data        <= data_next;
            sel_n       <= sel_next;
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench: scan order, snapshot coherence, blanking, dead time and reset
// across three parameterisations fed from the same stimulus.
module tb_bcd_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;

    logic [3:0] data_m,  data_nb, data_nd;
    logic [3:0] sel_m,   sel_nb,  sel_nd;
    logic       fs_m,    fs_nb,   fs_nd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(1), .BLANK_LEADING(1)) u_main (
        .clk(clk), .rst(rst), .digits_in(digits_in),
        .data(data_m), .sel_n(sel_m), .frame_start(fs_m));

    bcd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(1), .BLANK_LEADING(0)) u_noblank (
        .clk(clk), .rst(rst), .digits_in(digits_in),
        .data(data_nb), .sel_n(sel_nb), .frame_start(fs_nb));

    bcd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(0), .BLANK_LEADING(1)) u_nodead (
        .clk(clk), .rst(rst), .digits_in(digits_in),
        .data(data_nd), .sel_n(sel_nd), .frame_start(fs_nd));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_data"},  32'(data_m), 32'h0);
        check({tag, "_sel"},   32'(sel_m),  32'hE);
        check({tag, "_fs"},    32'(fs_m),   32'h0);
        check({tag, "_nd_sel"}, 32'(sel_nd), 32'hE);
    endtask

    // Entered on the cycle frame_start is expected; walks one full frame.
    // shown = expected data per digit with blanking, raw = digits without it.
    task automatic check_frame(input string tag, input logic [15:0] raw,
                               input logic [15:0] shown, input logic [15:0] next_in);
        logic [3:0] sel_on [4];
        logic [15:0] r, s;
        sel_on[0] = 4'b1110; sel_on[1] = 4'b1101; sel_on[2] = 4'b1011; sel_on[3] = 4'b0111;
        r = raw;
        s = shown;
        for (int j = 0; j < 4; j++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s_d%0d_c%0d_sel", tag, j, c), 32'(sel_m),
                      (c == 0) ? 32'hF : 32'(sel_on[j]));
                check($sformatf("%s_d%0d_c%0d_data", tag, j, c), 32'(data_m), 32'(s[4*j +: 4]));
                check($sformatf("%s_d%0d_c%0d_fs", tag, j, c), 32'(fs_m),
                      (j == 0 && c == 0) ? 32'h1 : 32'h0);
                check($sformatf("%s_d%0d_c%0d_nb_data", tag, j, c), 32'(data_nb), 32'(r[4*j +: 4]));
                check($sformatf("%s_d%0d_c%0d_nd_sel", tag, j, c), 32'(sel_nd), 32'(sel_on[j]));
                check($sformatf("%s_d%0d_c%0d_nd_data", tag, j, c), 32'(data_nd), 32'(s[4*j +: 4]));
                if (j == 2 && c == 0) digits_in = next_in;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int fs_at;
        rst       = 1'b1;
        digits_in = 16'h1234;
        repeat (3) @(negedge clk);
        check_reset_state("rst_hold");
        rst = 1'b0;

        // Digit 0 holds for the full first dwell; the first tick lands on edge 4.
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_k%0d_sel", k), 32'(sel_m), 32'hE);
            check($sformatf("post_rst_k%0d_fs", k),  32'(fs_m),  32'h0);
            check($sformatf("post_rst_k%0d_data", k), 32'(data_m), 32'h0);
        end
        @(negedge clk);
        check("first_tick_sel",  32'(sel_m),  32'hF);
        check("first_tick_data", 32'(data_m), 32'hF);
        repeat (12) @(negedge clk);

        check_frame("scan1",  16'h1234, 16'h1234, 16'h1234);
        check_frame("snap_a", 16'h1234, 16'h1234, 16'h5678);
        check_frame("snap_b", 16'h5678, 16'h5678, 16'h0070);
        check_frame("lz70",   16'h0070, 16'hFF70, 16'h0000);
        check_frame("lz00",   16'h0000, 16'hFFF0, 16'h00A0);
        check_frame("inv_a0", 16'h00A0, 16'hFFA0, 16'h1234);

        // Reset during digit 2's dwell, one cycle past its dead time.
        repeat (9) @(negedge clk);
        check("pre_rst_sel", 32'(sel_m), 32'hB);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst");
        rst = 1'b0;

        fs_at = -1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 4) begin
                check("mid_rst_snap_clr",    32'(data_m),  32'hF);
                check("mid_rst_snap_clr_nb", 32'(data_nb), 32'h0);
            end
            if (fs_m === 1'b1 && fs_at < 0) fs_at = k;
        end
        check("mid_rst_first_fs", 32'(fs_at), 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
